// File: rtl/tx_serial_pkg.sv
// +-----------------------------------------------------------------------+
// | tx_serial_pkg: FSM states, parity modes, frame-length helper          |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

package tx_serial_pkg;

  typedef enum logic [3:0] {
    INICIAL     = 4'd0,
    TRANSMISSAO = 4'd1,
    FINAL       = 4'd2
  } estado_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  function automatic int frame_len(input int data_bits, input int parity, input int stop_bits);
    return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tx_serial_param_gerador_tick.sv
// +-----------------------------------------------------------------------+
// | gerador_tick: modulo-TICKS counter, sync clear, one-cycle last tick   |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

module gerador_tick #(
  parameter int TICKS = 434
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = enable && !clear && (cnt_q == LAST);

endmodule

`default_nettype wire

// File: rtl/tx_serial_param.sv
// +-----------------------------------------------------------------------+
// | tx_serial_param: parametrised async serial transmitter with own FSM   |
// | Optional one-entry request buffer: define TX_SERIAL_BUFFER_EN         |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

module tx_serial_param
  import tx_serial_pkg::*;
#(
  parameter int DATA_BITS     = 7,
  parameter int PARITY        = 1,
  parameter int STOP_BITS     = 1,
  parameter int TICKS_PER_BIT = 434
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 partida,
  input  logic [DATA_BITS-1:0] dados,
  output logic                 saida_serial,
  output logic                 ocupado,
  output logic                 pronto,
  output logic [3:0]           db_estado
);

  localparam int N  = frame_len(DATA_BITS, PARITY, STOP_BITS);
  localparam int BW = $clog2(N + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(N - 1);

  generate
    if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2 || TICKS_PER_BIT < 2) begin : g_bad_params
      $fatal(1, "tx_serial_param: illegal parameter set");
    end
  endgenerate

  // Frame image, LSB leaves first: start, data, optional parity, stop bits.
  function automatic logic [N-1:0] build_frame(input logic [DATA_BITS-1:0] d);
    logic [N-1:0] f;
    f                = '1;
    f[0]             = 1'b0;
    f[DATA_BITS:1]   = d;
    if (PARITY == PAR_ODD) begin
      f[DATA_BITS+1] = ~^d;
    end else if (PARITY == PAR_EVEN) begin
      f[DATA_BITS+1] = ^d;
    end
    return f;
  endfunction

  estado_t       state_q, state_d;
  logic [N-1:0]  shift_q, shift_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic          tick;
  logic          tick_en;

`ifdef TX_SERIAL_BUFFER_EN
  logic [DATA_BITS-1:0] buf_data_q, buf_data_d;
  logic                 buf_valid_q, buf_valid_d;
`endif

  assign tick_en = (state_q == TRANSMISSAO);

  gerador_tick #(
    .TICKS(TICKS_PER_BIT)
  ) u_tick (
    .clock (clock),
    .reset (reset),
    .clear (!tick_en),
    .enable(tick_en),
    .tick  (tick)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
`ifdef TX_SERIAL_BUFFER_EN
    buf_data_d  = buf_data_q;
    buf_valid_d = buf_valid_q;
`endif

    case (state_q)
      INICIAL: begin
`ifdef TX_SERIAL_BUFFER_EN
        // A request captured during the FINAL cycle is drained from here.
        if (buf_valid_q) begin
          shift_d     = build_frame(buf_data_q);
          bit_cnt_d   = '0;
          buf_valid_d = 1'b0;
          state_d     = TRANSMISSAO;
        end else
`endif
        if (partida) begin
          shift_d   = build_frame(dados);
          bit_cnt_d = '0;
          state_d   = TRANSMISSAO;
        end
      end

      TRANSMISSAO: begin
        if (tick) begin
          shift_d   = {1'b1, shift_q[N-1:1]};
          bit_cnt_d = bit_cnt_q + BW'(1);
          if (bit_cnt_q == LAST_BIT) begin
            state_d = FINAL;
          end
        end
`ifdef TX_SERIAL_BUFFER_EN
        if (partida && !buf_valid_q) begin
          buf_data_d  = dados;
          buf_valid_d = 1'b1;
        end
`endif
      end

      FINAL: begin
        state_d = INICIAL;
`ifdef TX_SERIAL_BUFFER_EN
        if (buf_valid_q) begin
          shift_d     = build_frame(buf_data_q);
          bit_cnt_d   = '0;
          buf_valid_d = 1'b0;
          state_d     = TRANSMISSAO;
        end else if (partida) begin
          buf_data_d  = dados;
          buf_valid_d = 1'b1;
        end
`endif
      end

      default: begin
        state_d   = INICIAL;
        shift_d   = '1;
        bit_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= INICIAL;
      shift_q   <= '1;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

`ifdef TX_SERIAL_BUFFER_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      buf_data_q  <= '0;
      buf_valid_q <= 1'b0;
    end else begin
      buf_data_q  <= buf_data_d;
      buf_valid_q <= buf_valid_d;
    end
  end
`endif

  assign saida_serial = shift_q[0];
  assign ocupado      = (state_q == TRANSMISSAO);
  assign pronto       = (state_q == FINAL);
  assign db_estado    = state_q;

endmodule

`default_nettype wire

// File: tb/tb_tx_serial_param.sv
// +-----------------------------------------------------------------------+
// | tb_tx_serial_param: table vectors, corner sequences, random frames    |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_tx_serial_param;
  import tx_serial_pkg::*;

  localparam int T = 4;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       rst_a  [4];
  logic       part_a [4];
  logic [7:0] dat_a  [4];
  logic       sout_a [4];
  logic       ocup_a [4];
  logic       pron_a [4];
  logic [3:0] est_a  [4];

  tx_serial_param #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(1), .TICKS_PER_BIT(T)) dut0 (
    .clock(clock), .reset(rst_a[0]), .partida(part_a[0]), .dados(dat_a[0][6:0]),
    .saida_serial(sout_a[0]), .ocupado(ocup_a[0]), .pronto(pron_a[0]), .db_estado(est_a[0]));
  tx_serial_param #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .TICKS_PER_BIT(T)) dut1 (
    .clock(clock), .reset(rst_a[1]), .partida(part_a[1]), .dados(dat_a[1][6:0]),
    .saida_serial(sout_a[1]), .ocupado(ocup_a[1]), .pronto(pron_a[1]), .db_estado(est_a[1]));
  tx_serial_param #(.DATA_BITS(7), .PARITY(0), .STOP_BITS(1), .TICKS_PER_BIT(T)) dut2 (
    .clock(clock), .reset(rst_a[2]), .partida(part_a[2]), .dados(dat_a[2][6:0]),
    .saida_serial(sout_a[2]), .ocupado(ocup_a[2]), .pronto(pron_a[2]), .db_estado(est_a[2]));
  tx_serial_param #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(2), .TICKS_PER_BIT(T)) dut3 (
    .clock(clock), .reset(rst_a[3]), .partida(part_a[3]), .dados(dat_a[3]),
    .saida_serial(sout_a[3]), .ocupado(ocup_a[3]), .pronto(pron_a[3]), .db_estado(est_a[3]));

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual == expected) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  function automatic int cfg_db(input int id);
    return (id == 3) ? 8 : 7;
  endfunction
  function automatic int cfg_par(input int id);
    case (id)
      0: return PAR_ODD;
      1: return PAR_EVEN;
      2: return PAR_NONE;
      default: return PAR_ODD;
    endcase
  endfunction
  function automatic int cfg_sb(input int id);
    return (id == 3) ? 2 : 1;
  endfunction
  function automatic int cfg_n(input int id);
    return 1 + cfg_db(id) + ((cfg_par(id) != PAR_NONE) ? 1 : 0) + cfg_sb(id);
  endfunction

  // Reference: bit i of a frame, derived from counting ones in the payload.
  function automatic logic frame_bit(input int id, input logic [7:0] d, input int i);
    int db;
    int ones;
    db   = cfg_db(id);
    ones = 0;
    for (int j = 0; j < db; j++) ones += int'(d[j]);
    if (i == 0) return 1'b0;
    if (i <= db) return d[i-1];
    if (cfg_par(id) != PAR_NONE && i == db + 1)
      return (cfg_par(id) == PAR_ODD) ? ((ones % 2) == 0) : ((ones % 2) == 1);
    return 1'b1;
  endfunction

  int         exp_k[$];
  logic [7:0] exp_d[$];
  logic       obs_bits [16];

  task automatic expect_at(input int id, input int c, input int rst_c,
                           output logic e_line, output logic e_ocup, output logic e_pron);
    int span;
    e_line = 1'b1;
    e_ocup = 1'b0;
    e_pron = 1'b0;
    span   = cfg_n(id) * T;
    if (rst_c >= 0 && c >= rst_c) return;
    for (int f = 0; f < exp_k.size(); f++) begin
      if (c > exp_k[f] && c <= exp_k[f] + span) begin
        e_line = frame_bit(id, exp_d[f], (c - exp_k[f] - 1) / T);
        e_ocup = 1'b1;
      end else if (c == exp_k[f] + span + 1) begin
        e_pron = 1'b1;
      end
    end
  endtask

  // Launch a frame at cycle 0, optionally inject requests / a reset, and
  // compare every output each cycle against the reference timeline.
  task automatic run_seq(input int id, input logic [7:0] d0,
                         input int inj1_c, input logic [7:0] inj1_d,
                         input int inj2_c, input logic [7:0] inj2_d,
                         input int rst_c, input int ncyc,
                         output int first_pron, output int ocup_cnt, output int pron_cnt);
    int n;
    logic e_line, e_ocup, e_pron;
    n          = cfg_n(id);
    first_pron = -1;
    ocup_cnt   = 0;
    pron_cnt   = 0;
    exp_k.delete();
    exp_d.delete();
    exp_k.push_back(0);
    exp_d.push_back(d0);
`ifdef TX_SERIAL_BUFFER_EN
    if (inj1_c >= 1 && inj1_c <= n * T) begin
      exp_k.push_back(n * T + 1);
      exp_d.push_back(inj1_d);
    end
`endif
    for (int i = 0; i < 16; i++) obs_bits[i] = 1'bx;
    @(negedge clock);
    part_a[id] = 1'b1;
    dat_a[id]  = d0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clock);
      if (c == rst_c) rst_a[id] = 1'b1;
      if (c == rst_c + 1) rst_a[id] = 1'b0;
      #1;
      expect_at(id, c, rst_c, e_line, e_ocup, e_pron);
      check($sformatf("dut%0d line c%0d", id, c), int'(sout_a[id]), int'(e_line));
      check($sformatf("dut%0d ocupado c%0d", id, c), int'(ocup_a[id]), int'(e_ocup));
      check($sformatf("dut%0d pronto c%0d", id, c), int'(pron_a[id]), int'(e_pron));
      check($sformatf("dut%0d db_estado c%0d", id, c), int'(est_a[id]),
            e_ocup ? 1 : (e_pron ? 2 : 0));
      if (ocup_a[id]) ocup_cnt++;
      if (pron_a[id]) begin
        pron_cnt++;
        if (first_pron < 0) first_pron = c;
      end
      if ((c - 1) % T == 1 && (c - 1) / T < n) obs_bits[(c - 1) / T] = sout_a[id];
      if (c == inj1_c) begin
        part_a[id] = 1'b1;
        dat_a[id]  = inj1_d;
      end else if (c == inj2_c) begin
        part_a[id] = 1'b1;
        dat_a[id]  = inj2_d;
      end else begin
        part_a[id] = 1'b0;
      end
    end
    part_a[id] = 1'b0;
  endtask

  typedef struct {
    int          id;
    logic [7:0]  d;
    logic [15:0] seq;
    int          pron_c;
    int          ocup_cycles;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int fp, oc, pc, n, inj1, inj2, id;
    logic [15:0] obs;
    logic [7:0]  rd;

    vecs[0] = '{0, 8'h35, 16'b1101101010,   41, 40};
    vecs[1] = '{1, 8'h35, 16'b1001101010,   41, 40};
    vecs[2] = '{2, 8'h35, 16'b101101010,    37, 36};
    vecs[3] = '{3, 8'hFF, 16'b111111111110, 49, 48};

    for (int i = 0; i < 4; i++) begin
      rst_a[i]  = 1'b1;
      part_a[i] = 1'b0;
      dat_a[i]  = 8'h00;
    end
    repeat (2) @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("reset line dut%0d", i), int'(sout_a[i]), 1);
      check($sformatf("reset ocupado dut%0d", i), int'(ocup_a[i]), 0);
      check($sformatf("reset pronto dut%0d", i), int'(pron_a[i]), 0);
      check($sformatf("reset db_estado dut%0d", i), int'(est_a[i]), 0);
      rst_a[i] = 1'b0;
    end

    for (int v = 0; v < 4; v++) begin
      n = cfg_n(vecs[v].id);
      run_seq(vecs[v].id, vecs[v].d, -1, 8'h00, -1, 8'h00, -1, n * T + 6, fp, oc, pc);
      obs = '0;
      for (int i = 0; i < n; i++) obs[i] = obs_bits[i];
      check($sformatf("vec%0d line sequence", v), int'(obs), int'(vecs[v].seq));
      check($sformatf("vec%0d pronto cycle", v), fp, vecs[v].pron_c);
      check($sformatf("vec%0d ocupado cycles", v), oc, vecs[v].ocup_cycles);
      check($sformatf("vec%0d pronto count", v), pc, 1);
    end

    // Busy-time request on the 8-bit unit: dropped unless buffered.
    n = cfg_n(3);
    run_seq(3, 8'h5C, 10, 8'hAA, -1, 8'h00, -1, 2 * n * T + 30, fp, oc, pc);
`ifdef TX_SERIAL_BUFFER_EN
    check("busy request pronto count", pc, 2);
`else
    check("busy request pronto count", pc, 1);
    check("busy request ocupado cycles", oc, n * T);
`endif

    // Second request mid-frame, third while any buffer is full.
    n = cfg_n(0);
    run_seq(0, 8'h35, 12, 8'h41, 17, 8'h7E, -1, 2 * n * T + 20, fp, oc, pc);
`ifdef TX_SERIAL_BUFFER_EN
    check("buffered pronto count", pc, 2);
    check("buffered ocupado cycles", oc, 2 * n * T);
`else
    check("unbuffered pronto count", pc, 1);
`endif

    // Reset mid-frame, then a clean frame afterwards.
    n = cfg_n(1);
    run_seq(1, 8'h5A, -1, 8'h00, -1, 8'h00, 15, n * T + 10, fp, oc, pc);
    check("reset mid-frame pronto count", pc, 0);
    check("reset mid-frame ocupado cycles", oc, 14);
    run_seq(1, 8'h35, -1, 8'h00, -1, 8'h00, -1, n * T + 6, fp, oc, pc);
    obs = '0;
    for (int i = 0; i < n; i++) obs[i] = obs_bits[i];
    check("post-reset line sequence", int'(obs), int'(16'b1001101010));
    check("post-reset pronto cycle", fp, n * T + 1);

    for (int r = 0; r < 12; r++) begin
      id   = int'($urandom_range(0, 3));
      rd   = 8'($urandom);
      n    = cfg_n(id);
      inj1 = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, n * T - 10)) : -1;
      inj2 = (inj1 > 0 && $urandom_range(0, 1) == 1) ? inj1 + 3 : -1;
      run_seq(id, rd, inj1, 8'($urandom), inj2, 8'($urandom), -1, 2 * n * T + 8, fp, oc, pc);
      check($sformatf("random%0d pronto cycle", r), fp, n * T + 1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tx_serial_param.md
# tx_serial_param

Parametrised asynchronous serial transmitter: a self-contained successor to the fixed 7-bit/odd-parity transmitter datapath. It holds its own control FSM and baud-rate divider, so a single `partida` pulse sends one frame. Data width, parity mode, stop-bit count and bit period are configurable. It sits between the application logic (ASCII/command producers) and the board's serial TX pin.

## Interface
- `DATA_BITS`, default 7: payload bits per frame, legal 5..9.
- `PARITY`, default 1: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, default 1: legal 1 or 2.
- `TICKS_PER_BIT`, default 434: clock cycles per serial bit, legal ≥ 2. The default gives 115200 baud at 50 MHz.
- Illegal parameter values abort elaboration.

Ports:
- `clock` in 1: single system clock.
- `reset` in 1: asynchronous, active-high.
- `partida` in 1: start request, sampled on the rising edge of `clock`.
- `dados` in DATA_BITS: payload, sampled in the same cycle as the accepted `partida`.
- `saida_serial` out 1: serial line, idle high.
- `ocupado` out 1: high while a frame is in flight.
- `pronto` out 1: one-cycle pulse at the end of each frame.
- `db_estado` out 4: FSM state encoding, for debug displays.

## Operation
- Frame, transmitted in this order:
  - start bit 0;
  - `dados` LSB first;
  - parity bit, only if PARITY≠0. Odd parity = ~^dados, even parity = ^dados;
  - STOP_BITS stop bits, each 1.
- Frame length N = 1 + DATA_BITS + (PARITY≠0) + STOP_BITS bits.
- FSM states:
  - INICIAL (0): line high, waiting.
    - `partida` = 1 → load the shift register with the complete frame → TRANSMISSAO.
  - TRANSMISSAO (1): tick counter runs 0..TICKS_PER_BIT−1.
    - At the terminal tick, shift one bit and increment the bit counter.
    - After bit N−1 completes → FINAL.
  - FINAL (2): `pronto` = 1 for this cycle.
    - Next state is INICIAL, or TRANSMISSAO if a buffered request exists (see Configuration).
- `partida` while not in INICIAL, with no buffer: ignored. The frame in flight is unaffected.
- Every register is reset asynchronously: FSM = INICIAL, counters = 0, shift register = all ones.
- Reset values of the outputs: `saida_serial` = 1, `ocupado` = 0, `pronto` = 0, `db_estado` = 0.
- Reset mid-frame truncates the frame: the line returns high immediately, and no `pronto` is generated.

## Timing
- `partida` accepted at edge k → start bit is driven from cycle k+1.
- Bit i (0 = start) occupies cycles k+1+i·T through k+(i+1)·T, where T = TICKS_PER_BIT.
- `ocupado` is high from k+1 through k+N·T.
- `pronto` is high in cycle k+N·T+1 only. `ocupado` is low in that cycle.
- The earliest next `partida` is accepted in cycle k+N·T+2. Unbuffered minimum frame spacing is N·T+2 cycles.
- Outputs are registered; there is no combinational path from input to output.
- The bit counter is $clog2(N+1) bits wide and never wraps inside a frame.

## Configuration
- `TX_SERIAL_BUFFER_EN` defined: adds a one-entry holding register (data + valid).
  - `partida` during TRANSMISSAO or FINAL with the buffer empty: `dados` is captured and valid is set.
  - `partida` with the buffer already full: ignored.
  - In FINAL with valid set: the buffered frame is loaded, the next start bit begins in cycle k+N·T+2, and valid clears.
  - `ocupado` stays low for that single FINAL cycle.
  - Reset clears valid.
- `TX_SERIAL_BUFFER_EN` undefined: no holding register. Busy-time requests are dropped, and behaviour is exactly as described above.

## Structure
- Package `tx_serial_pkg` contains:
  - the FSM state localparams INICIAL/TRANSMISSAO/FINAL;
  - parity-mode constants PAR_NONE/PAR_ODD/PAR_EVEN;
  - a function computing N from the parameters.
- One sub-module, `gerador_tick`: a modulo-TICKS_PER_BIT counter with synchronous clear, an enable, and a one-cycle terminal-tick output.
- The shift register, bit counter and FSM live in the top module.

## Test plan
- Reset with DATA_BITS=7, PARITY=1, STOP_BITS=1, T=4, then `partida` with `dados`=7'h35.
  - Line sequence 0,1,0,1,0,1,1,0,1,1, each bit held 4 cycles.
  - `pronto` in cycle 41 after acceptance.
- Same frame with PARITY=2: parity bit = 0. With PARITY=0: 9-bit frame, and `pronto` in cycle 37.
- DATA_BITS=8, STOP_BITS=2, `dados`=8'hFF, odd parity.
  - Line: start 0, eight 1s, parity 1, then 1,1.
  - `ocupado` high for 48 cycles.
- Unbuffered: second `partida` (8'hAA) at cycle 10 of a frame → ignored. Only one `pronto`, and the line stays idle afterwards.
- Buffered build: second `partida` (7'h41) mid-frame.
  - The second start bit begins exactly 1 cycle after the first frame's `pronto`.
  - A third `partida` while the buffer is full is dropped.
- Assert `reset` at cycle 15 of a frame → `saida_serial`=1 and `ocupado`=0 immediately, no `pronto`. A fresh `partida` after release sends a correct frame.
